// File: rtl/mc2_joy_pkg.sv
// -----------------------------------------------------------------------------
// mc2_joy_pkg
// Shared definitions for the MC2/Unamiga Sega joystick scanner.
//   state_e     : scan FSM states (IDLE, then eight select phases P0..P7)
//   JOY_*       : bit positions inside a 12-bit joystick word {M,X,Y,Z,S,A,C,B,R,L,D,U}
//   PIN_*       : bit positions inside a 6-bit raw port word {p9,p6,right,left,down,up}
// -----------------------------------------------------------------------------
package mc2_joy_pkg;

   typedef enum logic [3:0] {
      IDLE,
      P0,
      P1,
      P2,
      P3,
      P4,
      P5,
      P6,
      P7
   } state_e;

   localparam int JOY_U = 0;
   localparam int JOY_D = 1;
   localparam int JOY_L = 2;
   localparam int JOY_R = 3;
   localparam int JOY_B = 4;
   localparam int JOY_C = 5;
   localparam int JOY_A = 6;
   localparam int JOY_S = 7;
   localparam int JOY_Z = 8;
   localparam int JOY_Y = 9;
   localparam int JOY_X = 10;
   localparam int JOY_M = 11;

   localparam int PIN_UP    = 0;
   localparam int PIN_DOWN  = 1;
   localparam int PIN_LEFT  = 2;
   localparam int PIN_RIGHT = 3;
   localparam int PIN_P6    = 4;
   localparam int PIN_P9    = 5;

endpackage

// File: rtl/mc2_joy_tick.sv
// -----------------------------------------------------------------------------
// mc2_joy_tick
// Free-running prescaler that paces the joystick scan. Counts 0..CLK_DIV-1 and
// raises tick_o for one clk_i cycle on the last count, just before it wraps.
//   clk_i    in   system clock
//   res_n_i  in   asynchronous active-low reset (counter restarts at 0)
//   tick_o   out  one-cycle phase tick
// -----------------------------------------------------------------------------
module mc2_joy_tick #(
   parameter int CLK_DIV = 600
) (
   input  logic clk_i,
   input  logic res_n_i,
   output logic tick_o
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = (cnt_q == LAST);
   assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mc2_joy_reader.sv
// -----------------------------------------------------------------------------
// mc2_joy_reader
// Multi-port Sega joystick scanner. Toggles the shared select line through an
// eight-phase sequence, decodes Master System / Mega Drive 3- and 6-button pads
// on every port and publishes all ports atomically once per scan.
//   clk_i      in   system clock
//   res_n_i    in   asynchronous active-low reset
//   pins_i     in   raw active-low pins, per port {p9,p6,right,left,down,up}
//   sel_o      out  select line (pin 7) shared by all ports
//   joy_o      out  per port {M,X,Y,Z,S,A,C,B,R,L,D,U}, 1 = pressed
//   six_btn_o  out  per port, 6-button pad seen on last completed scan
//   md_o       out  per port, Mega Drive pad seen on last completed scan
//   valid_o    out  one-cycle pulse when joy_o/six_btn_o/md_o were updated
// -----------------------------------------------------------------------------
module mc2_joy_reader
   import mc2_joy_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int CLK_DIV    = 600,
   parameter int IDLE_TICKS = 100
) (
   input  logic                      clk_i,
   input  logic                      res_n_i,
   input  logic [6*NUM_PORTS-1:0]    pins_i,
   output logic                      sel_o,
   output logic [12*NUM_PORTS-1:0]   joy_o,
   output logic [NUM_PORTS-1:0]      six_btn_o,
   output logic [NUM_PORTS-1:0]      md_o,
   output logic                      valid_o
);

   localparam int IW = (IDLE_TICKS > 2) ? $clog2(IDLE_TICKS) : 1;
   localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_TICKS > 0) ? IDLE_TICKS - 1 : 0);

   logic                   tick;
   logic [6*NUM_PORTS-1:0] pins_s1_q;
   logic [6*NUM_PORTS-1:0] pins_s2_q;
   state_e                 state_q, state_d;
   logic [IW-1:0]          idle_q, idle_d;
   logic                   sel_q, sel_d;
   logic                   commit_q, commit_d;
   logic                   valid_q;
   logic                   samp_p2, samp_p3, samp_p5, samp_p6;

   mc2_joy_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk_i   (clk_i),
      .res_n_i (res_n_i),
      .tick_o  (tick)
   );

   // Sampling phases see pins that settled for a full tick after the last
   // select change, because sel_o only moves on the previous tick.
   assign samp_p2 = tick && (state_q == P2);
   assign samp_p3 = tick && (state_q == P3);
   assign samp_p5 = tick && (state_q == P5);
   assign samp_p6 = tick && (state_q == P6);

   always_comb begin
      state_d  = state_q;
      idle_d   = idle_q;
      sel_d    = sel_q;
      commit_d = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               sel_d = 1'b1;
               if (idle_q == IDLE_LAST) begin
                  idle_d  = '0;
                  state_d = P0;
               end else begin
                  idle_d = idle_q + IW'(1);
               end
            end
            P0: begin sel_d = 1'b0; state_d = P1; end
            P1: begin sel_d = 1'b1; state_d = P2; end
            P2: begin sel_d = 1'b0; state_d = P3; end
            P3: begin sel_d = 1'b1; state_d = P4; end
            P4: begin sel_d = 1'b0; state_d = P5; end
            P5: begin sel_d = 1'b1; state_d = P6; end
            P6: begin sel_d = 1'b0; state_d = P7; end
            P7: begin
               sel_d    = 1'b1;
               // Commit is deferred one clk so it never shares a cycle with a tick.
               commit_d = 1'b1;
               state_d  = (IDLE_TICKS == 0) ? P0 : IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         pins_s1_q <= '1;
         pins_s2_q <= '1;
         state_q   <= IDLE;
         idle_q    <= '0;
         sel_q     <= 1'b1;
         commit_q  <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         pins_s1_q <= pins_i;
         pins_s2_q <= pins_s1_q;
         state_q   <= state_d;
         idle_q    <= idle_d;
         sel_q     <= sel_d;
         commit_q  <= commit_d;
         valid_q   <= commit_q;
      end
   end

   assign sel_o   = sel_q;
   assign valid_o = valid_q;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      logic [5:0]  pv;
      logic [11:0] shadow_q, shadow_d;
      logic        md_tmp_q, md_tmp_d;
      logic        six_tmp_q, six_tmp_d;
      logic [11:0] joy_q;
      logic        md_q;
      logic        six_q;

      assign pv = pins_s2_q[6*g +: 6];

      always_comb begin
         shadow_d  = shadow_q;
         md_tmp_d  = md_tmp_q;
         six_tmp_d = six_tmp_q;
         if (samp_p2) begin
            shadow_d[JOY_U] = ~pv[PIN_UP];
            shadow_d[JOY_D] = ~pv[PIN_DOWN];
            shadow_d[JOY_L] = ~pv[PIN_LEFT];
            shadow_d[JOY_R] = ~pv[PIN_RIGHT];
            shadow_d[JOY_B] = ~pv[PIN_P6];
            shadow_d[JOY_C] = ~pv[PIN_P9];
            six_tmp_d       = 1'b0;
         end
         if (samp_p3) begin
            // Only Mega Drive pads force left and right low while select is low.
            if (!pv[PIN_LEFT] && !pv[PIN_RIGHT]) begin
               md_tmp_d        = 1'b1;
               shadow_d[JOY_A] = ~pv[PIN_P6];
               shadow_d[JOY_S] = ~pv[PIN_P9];
            end else begin
               md_tmp_d        = 1'b0;
               shadow_d[JOY_A] = 1'b0;
               shadow_d[JOY_S] = 1'b0;
            end
         end
         if (samp_p5) begin
            // Third select-low cycle: a 6-button pad pulls the whole d-pad low.
            if (md_tmp_q && !(pv[PIN_UP] | pv[PIN_DOWN] | pv[PIN_LEFT] | pv[PIN_RIGHT])) begin
               six_tmp_d = 1'b1;
            end
         end
         if (samp_p6) begin
            shadow_d[JOY_Z] = six_tmp_q & ~pv[PIN_UP];
            shadow_d[JOY_Y] = six_tmp_q & ~pv[PIN_DOWN];
            shadow_d[JOY_X] = six_tmp_q & ~pv[PIN_LEFT];
            shadow_d[JOY_M] = six_tmp_q & ~pv[PIN_RIGHT];
         end
      end

      always_ff @(posedge clk_i or negedge res_n_i) begin
         if (!res_n_i) begin
            shadow_q  <= '0;
            md_tmp_q  <= 1'b0;
            six_tmp_q <= 1'b0;
            joy_q     <= '0;
            md_q      <= 1'b0;
            six_q     <= 1'b0;
         end else begin
            shadow_q  <= shadow_d;
            md_tmp_q  <= md_tmp_d;
            six_tmp_q <= six_tmp_d;
            if (commit_q) begin
               joy_q <= shadow_q;
               md_q  <= md_tmp_q;
               six_q <= six_tmp_q;
            end
         end
      end

      assign joy_o[12*g +: 12] = joy_q;
      assign six_btn_o[g]      = six_q;
      assign md_o[g]           = md_q;
   end

endmodule

// File: tb/tb_mc2_joy_reader.sv
// -----------------------------------------------------------------------------
// tb_mc2_joy_reader
// Bench for mc2_joy_reader with two ports. Each port is driven by a pad model
// (absent, Master System, Mega Drive 3-button or 6-button) that reacts to the
// select line edges the way a real pad does; expected outputs come from what
// each pad type is able to report for its held buttons.
// -----------------------------------------------------------------------------
module tb_mc2_joy_reader;

   localparam int NP   = 2;
   localparam int CD   = 4;
   localparam int IT   = 8;
   localparam int SCAN = (8 + IT) * CD;

   // pad kinds
   localparam int K_NONE = 0;
   localparam int K_SMS  = 1;
   localparam int K_MD3  = 2;
   localparam int K_MD6  = 3;

   logic              clk = 1'b0;
   logic              res_n = 1'b0;
   logic [6*NP-1:0]   pins;
   logic              sel;
   logic [12*NP-1:0]  joy;
   logic [NP-1:0]     six;
   logic [NP-1:0]     md;
   logic              valid;

   int                total = 0;
   int                bad = 0;

   int                kind [NP];
   logic [11:0]       btn  [NP];
   int                falls = 0;
   time               t_rise = 0;

   always #5 clk = ~clk;

   mc2_joy_reader #(
      .NUM_PORTS  (NP),
      .CLK_DIV    (CD),
      .IDLE_TICKS (IT)
   ) dut (
      .clk_i     (clk),
      .res_n_i   (res_n),
      .pins_i    (pins),
      .sel_o     (sel),
      .joy_o     (joy),
      .six_btn_o (six),
      .md_o      (md),
      .valid_o   (valid)
   );

   // Real 6-button pads count select falls and forget the count after the
   // select line has rested high for a while.
   always @(posedge sel) t_rise = $time;
   always @(negedge sel) begin
      if ($time - t_rise > 150) falls = 1;
      else falls = falls + 1;
   end

   // Pins a pad pulls low for its held buttons (b uses the joy_o bit layout).
   function automatic logic [5:0] pad_pins(input int k, input logic [11:0] b,
                                           input logic s, input int f);
      logic [5:0] low;
      low = 6'b0;
      case (k)
         K_SMS: low = b[5:0];
         K_MD3: low = s ? b[5:0] : {b[7:6], 2'b11, b[1:0]};
         K_MD6: begin
            if (s)           low = (f == 3) ? {b[5:4], b[11:8]} : b[5:0];
            else if (f == 3) low = {b[7:6], 4'b1111};
            else if (f >= 4) low = {b[7:6], 4'b0000};
            else             low = {b[7:6], 2'b11, b[1:0]};
         end
         default: low = 6'b0;
      endcase
      return ~low;
   endfunction

   always_comb begin
      pins[5:0]  = pad_pins(kind[0], btn[0], sel, falls);
      pins[11:6] = pad_pins(kind[1], btn[1], sel, falls);
   end

   // What a scan must report for a pad: {six, md, joy}.
   function automatic logic [13:0] expect_scan(input int k, input logic [11:0] b);
      case (k)
         K_SMS:   return {2'b00, 6'b0, b[5:0]};
         K_MD3:   return {2'b01, 4'b0, b[7:0]};
         K_MD6:   return {2'b11, b};
         default: return 14'b0;
      endcase
   endfunction

   // Random buttons a physical d-pad can produce (no opposite directions).
   function automatic logic [11:0] rand_btn();
      logic [11:0] b;
      b = 12'($urandom);
      if (b[2] && b[3]) b[3] = 1'b0;
      if (b[0] && b[1]) b[1] = 1'b0;
      return b;
   endfunction

   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (valid !== 1'b1 && cycles < 400);
      if (valid !== 1'b1) begin
         total++; bad++;
         $display("FAIL valid_timeout: valid_o=%b after %0d clk, required 1", valid, cycles);
      end
   endtask

   // Apply a pad setup and let one full scan complete with it.
   task automatic settle_scan(input int k0, input logic [11:0] b0,
                              input int k1, input logic [11:0] b1);
      int c;
      kind[0] = k0; btn[0] = b0;
      kind[1] = k1; btn[1] = b1;
      wait_valid(c);
      wait_valid(c);
   endtask

   task automatic test_reset();
      int n;
      res_n = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      total++; if (sel !== 1'b1) begin bad++; $display("FAIL reset_sel: got %b want 1", sel); end
      total++; if (joy !== '0) begin bad++; $display("FAIL reset_joy: got %h want 0", joy); end
      total++; if (six !== '0) begin bad++; $display("FAIL reset_six: got %b want 0", six); end
      total++; if (md !== '0) begin bad++; $display("FAIL reset_md: got %b want 0", md); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
      res_n = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (sel !== 1'b0 && n < 200);
      total++;
      if (n != 9 * CD) begin bad++; $display("FAIL first_sel_fall: got %0d clk want %0d", n, 9 * CD); end
   endtask

   task automatic test_six_button();
      settle_scan(K_MD6, 12'h480, K_NONE, 12'h000);
      total++; if (joy[11:0] !== 12'h480) begin bad++; $display("FAIL six_joy0: got %h want 480", joy[11:0]); end
      total++; if (joy[23:12] !== 12'h000) begin bad++; $display("FAIL six_joy1: got %h want 000", joy[23:12]); end
      total++; if (six !== 2'b01) begin bad++; $display("FAIL six_flag: got %b want 01", six); end
      total++; if (md !== 2'b01) begin bad++; $display("FAIL six_md: got %b want 01", md); end
      @(negedge clk);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL valid_width: got %b want 0", valid); end
   endtask

   task automatic test_three_button();
      settle_scan(K_NONE, 12'h000, K_MD3, 12'h048);
      total++; if (joy[23:12] !== 12'h048) begin bad++; $display("FAIL md3_joy1: got %h want 048", joy[23:12]); end
      total++; if (six[1] !== 1'b0) begin bad++; $display("FAIL md3_six: got %b want 0", six[1]); end
      total++; if (md[1] !== 1'b1) begin bad++; $display("FAIL md3_md: got %b want 1", md[1]); end
      total++; if (joy[11:0] !== 12'h000) begin bad++; $display("FAIL md3_joy0: got %h want 000", joy[11:0]); end
   endtask

   task automatic test_master_system();
      settle_scan(K_SMS, 12'h030, K_NONE, 12'h000);
      total++; if (joy[11:0] !== 12'h030) begin bad++; $display("FAIL sms_joy0: got %h want 030", joy[11:0]); end
      total++; if (md[0] !== 1'b0) begin bad++; $display("FAIL sms_md: got %b want 0", md[0]); end
      total++; if (six[0] !== 1'b0) begin bad++; $display("FAIL sms_six: got %b want 0", six[0]); end
   endtask

   task automatic test_absent_period();
      int c;
      settle_scan(K_NONE, 12'h000, K_NONE, 12'h000);
      total++; if (joy !== '0) begin bad++; $display("FAIL absent_joy: got %h want 0", joy); end
      total++; if (six !== '0) begin bad++; $display("FAIL absent_six: got %b want 0", six); end
      total++; if (md !== '0) begin bad++; $display("FAIL absent_md: got %b want 0", md); end
      wait_valid(c);
      total++; if (c != SCAN) begin bad++; $display("FAIL valid_period: got %0d clk want %0d", c, SCAN); end
   endtask

   task automatic test_random();
      logic [13:0] exp0, exp1;
      for (int i = 0; i < 8; i++) begin
         settle_scan(int'($urandom_range(0, 3)), rand_btn(), int'($urandom_range(0, 3)), rand_btn());
         exp0 = expect_scan(kind[0], btn[0]);
         exp1 = expect_scan(kind[1], btn[1]);
         total++;
         if ({six[0], md[0], joy[11:0]} !== exp0) begin
            bad++;
            $display("FAIL rand_port0 it=%0d kind=%0d btn=%h: got %h want %h",
                     i, kind[0], btn[0], {six[0], md[0], joy[11:0]}, exp0);
         end
         total++;
         if ({six[1], md[1], joy[23:12]} !== exp1) begin
            bad++;
            $display("FAIL rand_port1 it=%0d kind=%0d btn=%h: got %h want %h",
                     i, kind[1], btn[1], {six[1], md[1], joy[23:12]}, exp1);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      logic        prev;
      int          nf, n, guard;
      bit          early;
      logic [13:0] exp0;
      settle_scan(K_MD6, 12'h0F0, K_MD3, 12'h0C1);
      total++;
      if ({six, md, joy} !== {expect_scan(K_MD6, 12'h0F0) >> 12 & 14'h3 | 14'h0, 2'b0, 24'h0} &&
          {six[0], md[0], joy[11:0]} !== expect_scan(K_MD6, 12'h0F0)) begin
         bad++;
         $display("FAIL pre_abort_port0: got %h want %h", {six[0], md[0], joy[11:0]},
                  expect_scan(K_MD6, 12'h0F0));
      end
      // Two select falls then the following rise put the scan in P4.
      nf = 0; guard = 0; prev = sel;
      while (!(nf == 2 && sel === 1'b1) && guard < 400) begin
         @(negedge clk);
         guard++;
         if (prev === 1'b1 && sel === 1'b0) nf++;
         prev = sel;
      end
      total++;
      if (guard >= 400) begin bad++; $display("FAIL find_p4: timed out after %0d clk", guard); end
      res_n = 1'b0;
      #1;
      total++; if (joy !== '0) begin bad++; $display("FAIL abort_joy: got %h want 0", joy); end
      total++; if (six !== '0 || md !== '0) begin bad++; $display("FAIL abort_flags: got six=%b md=%b want 0", six, md); end
      total++; if (valid !== 1'b0 || sel !== 1'b1) begin bad++; $display("FAIL abort_ctl: got valid=%b sel=%b want 0/1", valid, sel); end
      repeat (3) @(negedge clk);
      kind[0] = K_SMS;  btn[0] = 12'h011;
      kind[1] = K_NONE; btn[1] = 12'h000;
      res_n = 1'b1;
      n = 0; early = 1'b0;
      do begin
         @(posedge clk); #1;
         n++;
         if (valid !== 1'b1 && joy !== '0) early = 1'b1;
      end while (valid !== 1'b1 && n < 400);
      exp0 = expect_scan(K_SMS, 12'h011);
      total++; if (early) begin bad++; $display("FAIL abort_leak: joy nonzero before first valid, want 0"); end
      total++; if (n != SCAN + 1) begin bad++; $display("FAIL abort_first_valid: got %0d clk want %0d", n, SCAN + 1); end
      total++;
      if ({six[0], md[0], joy[11:0]} !== exp0 || joy[23:12] !== 12'h000) begin
         bad++;
         $display("FAIL abort_fresh_scan: got %h want %h/000", {six[0], md[0], joy}, exp0);
      end
   endtask

   initial begin
      kind[0] = K_NONE; btn[0] = 12'h000;
      kind[1] = K_NONE; btn[1] = 12'h000;
      test_reset();
      test_six_button();
      test_three_button();
      test_master_system();
      test_absent_period();
      test_random();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
